mfi_check_sequencer: RTL and testbench
======================================

Name: mfi_check_sequencer

Overview:
Sequencer that drives the control inputs (reset, trig, check) of the MFI property checkers in simulation-based and bounded runs. It watches the retirement interface, fires trig on the first eligible retirement inside a configurable window, then fires check a fixed number of cycles later. It also records trig_order and whether the successor instruction retired, so benches can cross-check the checkers' verdicts.

Parameters:
RESET_CYCLES, 2, cycles check_reset is held after global reset release (>=1)
TRIG_MIN, 4, earliest cycle count (post-hold) at which trig may fire
TRIG_MAX, 64, cycle count at which an unfired trig becomes a timeout (TRIG_MAX > TRIG_MIN)
CHECK_DELAY, 16, cycles from the trig cycle to the check cycle (>=1)
CNT_W, 8, width of the cycle and delay counters (2**CNT_W > max(TRIG_MAX, CHECK_DELAY))

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high
mfi_valid  in  1  retirement valid
mfi_order  in  32  retirement order number
mfi_halt  in  1  retiring instruction halts
check_reset  out  1  reset to checkers
trig  out  1  trigger pulse to checkers (Mealy, combinational)
check  out  1  check pulse to checkers (registered)
trig_order  out  32  mfi_order captured at trig
next_seen  out  1  order trig_order+1 retired after trig
halt_seen  out  1  halting retirement seen while armed
done  out  1  sequence complete, sticky
timeout  out  1  no eligible retirement before TRIG_MAX, sticky

Behaviour:
- Reset (async assert, sync release): state=HOLD, cnt=0, check_reset=1, check=0, trig_order=0, next_seen=0, halt_seen=0, done=0, timeout=0. Reset mid-sequence aborts from any state, with the same values.
- States: HOLD, WAIT, ARMED, CHECK, DONE.
- HOLD: check_reset=1. cnt increments. When cnt==RESET_CYCLES-1: go to WAIT, cnt<=0, check_reset<=0.
- WAIT:
  - Eligible cycle: cnt>=TRIG_MIN && mfi_valid && !mfi_halt.
  - On an eligible cycle: trig=1 in that same cycle (combinational). trig_order<=mfi_order, cnt<=0, go to ARMED.
  - Otherwise, when cnt==TRIG_MAX: timeout<=1, done<=1, go to DONE. A retirement in the cnt==TRIG_MAX cycle still wins, because eligibility is checked first.
  - Otherwise cnt++.
  - trig is 0 in every state except WAIT.
- ARMED:
  - cnt++.
  - If mfi_valid && mfi_order==trig_order+1 (32-bit wrap, 0xFFFFFFFF+1==0): next_seen<=1.
  - If mfi_valid && mfi_halt: halt_seen<=1 (no early exit).
  - When cnt==CHECK_DELAY-1: go to CHECK. check is registered high for the next cycle only, so check is asserted exactly CHECK_DELAY cycles after trig.
  - Retirements in the trig cycle itself do not set next_seen.
- CHECK: check=1 for one cycle. next_seen is still updated this cycle. Next state is DONE with done<=1.
- DONE: all pulses 0. Flags hold until reset.
- Exactly one trig and at most one check per reset epoch.
- Counters saturate at all-ones and never wrap (guarded by the CNT_W rule).

Decomposition:
- Package mfi_check_pkg holds:
  - state enum seq_state_e {HOLD, WAIT, ARMED, CHECK, DONE}
  - MFI_ORDER_W=32 and shared default window constants
- Single flat module; no sub-module warranted. Counters and FSM fit in about 200 lines.

Test Plan:
- Defaults; first valid, non-halt retirement at post-hold cycle 7 with order 5 -> trig=1 exactly that cycle, trig_order=5; check high 16 cycles later for one cycle; done=1; timeout=0.
- Order 6 retires 3 cycles after trig -> next_seen=1 by the check cycle. With no order-6 retirement -> next_seen=0 at done.
- Valid retirements only at cycles 0–3, and one at cycle 5 with mfi_halt=1, then one non-halt at cycle 9 -> trig fires at cycle 9 only.
- No valid retirements through cycle 64 -> timeout=1, done=1, trig and check never asserted.
- trig_order=0xFFFFFFFF, followed by a retirement of order 0 -> next_seen=1 (wrap).
- reset asserted during ARMED -> all outputs return to reset values immediately. After release: check_reset high for 2 cycles, then a fresh trig window opens.

Source files
------------

// File: rtl/mfi_check_sequencer_pkg.sv
// Shared types and default window constants for the MFI checker sequencer.
// The FSM state type is also exported through the interface as a debug signal.
package mfi_check_pkg;

    localparam int MFI_ORDER_W = 32;

    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_TRIG_MIN     = 4;
    localparam int DEF_TRIG_MAX     = 64;
    localparam int DEF_CHECK_DELAY  = 16;
    localparam int DEF_CNT_W        = 8;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        WAIT  = 3'd1,
        ARMED = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/mfi_check_sequencer_if.sv
// Retirement inputs and checker-control outputs of the sequencer, plus a state tap.
// The retirement side has no ready: a retirement is consumed in any cycle mfi_valid is high.
interface mfi_check_sequencer_if;
    import mfi_check_pkg::*;

    logic                   mfi_valid;
    logic [MFI_ORDER_W-1:0] mfi_order;
    logic                   mfi_halt;

    logic                   check_reset;
    logic                   trig;
    logic                   check;
    logic [MFI_ORDER_W-1:0] trig_order;
    logic                   next_seen;
    logic                   halt_seen;
    logic                   done;
    logic                   timeout;
    seq_state_e             dbg_state;

    modport master (
        output mfi_valid, mfi_order, mfi_halt,
        input  check_reset, trig, check, trig_order, next_seen,
        input  halt_seen, done, timeout, dbg_state
    );

    modport slave (
        input  mfi_valid, mfi_order, mfi_halt,
        output check_reset, trig, check, trig_order, next_seen,
        output halt_seen, done, timeout, dbg_state
    );

endinterface

// File: rtl/mfi_check_sequencer.sv
// Drives reset/trig/check of the MFI property checkers from the retirement stream
// and records the trig order plus successor/halt observations for cross-checking.
module mfi_check_sequencer
    import mfi_check_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int TRIG_MIN     = DEF_TRIG_MIN,
    parameter int TRIG_MAX     = DEF_TRIG_MAX,
    parameter int CHECK_DELAY  = DEF_CHECK_DELAY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input logic                  clock,
    input logic                  reset,
    mfi_check_sequencer_if.slave mfi
);

    localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TRIG_MIN  = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] L_TRIG_MAX  = CNT_W'(TRIG_MAX);
    // cnt in ARMED is (cycles since trig - 1); leaving one cycle early puts check at trig+CHECK_DELAY.
    localparam logic [CNT_W-1:0] L_ARM_LAST  = CNT_W'(CHECK_DELAY - 2);
    localparam bit               L_DIRECT    = (CHECK_DELAY == 1);

    seq_state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                   r_check_reset, w_check_reset_nxt;
    logic                   r_check, w_check_nxt;
    logic [MFI_ORDER_W-1:0] r_trig_order, w_trig_order_nxt;
    logic                   r_next_seen, w_next_seen_nxt;
    logic                   r_halt_seen, w_halt_seen_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_timeout, w_timeout_nxt;
    logic                   w_trig;
    logic                   w_eligible;
    logic                   w_succ_hit;

    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_eligible = (r_cnt >= L_TRIG_MIN) && mfi.mfi_valid && !mfi.mfi_halt;
    assign w_succ_hit = mfi.mfi_valid && (mfi.mfi_order == r_trig_order + 32'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= HOLD;
            r_cnt         <= '0;
            r_check_reset <= 1'b1;
            r_check       <= 1'b0;
            r_trig_order  <= '0;
            r_next_seen   <= 1'b0;
            r_halt_seen   <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_check_reset <= w_check_reset_nxt;
            r_check       <= w_check_nxt;
            r_trig_order  <= w_trig_order_nxt;
            r_next_seen   <= w_next_seen_nxt;
            r_halt_seen   <= w_halt_seen_nxt;
            r_done        <= w_done_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_check_reset_nxt = r_check_reset;
        w_check_nxt       = 1'b0;
        w_trig_order_nxt  = r_trig_order;
        w_next_seen_nxt   = r_next_seen;
        w_halt_seen_nxt   = r_halt_seen;
        w_done_nxt        = r_done;
        w_timeout_nxt     = r_timeout;
        w_trig            = 1'b0;

        case (r_state)
            HOLD: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == L_HOLD_LAST) begin
                    w_state_nxt       = WAIT;
                    w_cnt_nxt         = '0;
                    w_check_reset_nxt = 1'b0;
                end
            end
            WAIT: begin
                // Eligibility is tested before the timeout so a TRIG_MAX-cycle retirement still fires.
                if (w_eligible) begin
                    w_trig           = 1'b1;
                    w_trig_order_nxt = mfi.mfi_order;
                    w_cnt_nxt        = '0;
                    if (L_DIRECT) begin
                        w_state_nxt = CHECK;
                        w_check_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ARMED;
                    end
                end else if (r_cnt == L_TRIG_MAX) begin
                    w_state_nxt   = DONE;
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ARMED: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_succ_hit) w_next_seen_nxt = 1'b1;
                if (mfi.mfi_valid && mfi.mfi_halt) w_halt_seen_nxt = 1'b1;
                if (r_cnt == L_ARM_LAST) begin
                    w_state_nxt = CHECK;
                    w_check_nxt = 1'b1;
                end
            end
            CHECK: begin
                if (w_succ_hit) w_next_seen_nxt = 1'b1;
                w_state_nxt = DONE;
                w_done_nxt  = 1'b1;
            end
            DONE: begin
            end
            default: begin
                w_state_nxt = HOLD;
            end
        endcase
    end

    assign mfi.check_reset = r_check_reset;
    assign mfi.trig        = w_trig;
    assign mfi.check       = r_check;
    assign mfi.trig_order  = r_trig_order;
    assign mfi.next_seen   = r_next_seen;
    assign mfi.halt_seen   = r_halt_seen;
    assign mfi.done        = r_done;
    assign mfi.timeout     = r_timeout;
    assign mfi.dbg_state   = r_state;

endmodule

// File: tb/tb_mfi_check_sequencer.sv
// Directed scenarios for mfi_check_sequencer with a timestamp-based reference model
// checked every cycle, plus literal per-scenario expectations.
module tb_mfi_check_sequencer;
    import mfi_check_pkg::*;

    localparam int RC   = 2;
    localparam int TMIN = 4;
    localparam int TMAX = 64;
    localparam int CD   = 16;

    typedef struct {
        int          k;
        logic [31:0] order;
        logic        halt;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    mfi_check_sequencer_if bus ();

    mfi_check_sequencer #(
        .RESET_CYCLES(RC), .TRIG_MIN(TMIN), .TRIG_MAX(TMAX), .CHECK_DELAY(CD), .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mfi  (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    ev_t evs[$];

    // Model state: k counts cycles since reset release; events are kept as timestamps.
    int          k = 0;
    int          m_trig_k = -1;
    logic [31:0] m_order = '0;
    bit          m_ns = 0;
    bit          m_hs = 0;
    bit          e_elig, e_to, e_done, e_check;
    logic [31:0] e_torder;

    int n_trig = 0, n_check = 0, trig_at = -1, check_at = -1, cr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t k=%0d)", name, act, exp, $time, k);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_check_reset", bus.check_reset, 1);
            chk("rst_trig", bus.trig, 0);
            chk("rst_check", bus.check, 0);
            chk("rst_trig_order", bus.trig_order, 0);
            chk("rst_next_seen", bus.next_seen, 0);
            chk("rst_halt_seen", bus.halt_seen, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_timeout", bus.timeout, 0);
            k = 0; m_trig_k = -1; m_order = '0; m_ns = 0; m_hs = 0;
            n_trig = 0; n_check = 0; trig_at = -1; check_at = -1; cr_cnt = 0;
        end else begin
            e_elig   = (m_trig_k < 0) && (k >= RC + TMIN) && (k <= RC + TMAX)
                       && bus.mfi_valid && !bus.mfi_halt;
            e_to     = (m_trig_k < 0) && (k > RC + TMAX);
            e_check  = (m_trig_k >= 0) && (k == m_trig_k + CD);
            e_done   = e_to || ((m_trig_k >= 0) && (k > m_trig_k + CD));
            e_torder = (m_trig_k >= 0) ? m_order : 32'd0;

            chk("check_reset", bus.check_reset, (k < RC) ? 1 : 0);
            chk("trig", bus.trig, e_elig);
            chk("check", bus.check, e_check);
            chk("trig_order", bus.trig_order, e_torder);
            chk("next_seen", bus.next_seen, m_ns);
            chk("halt_seen", bus.halt_seen, m_hs);
            chk("done", bus.done, e_done);
            chk("timeout", bus.timeout, e_to);

            if (bus.trig) begin n_trig++; trig_at = k; end
            if (bus.check) begin n_check++; check_at = k; end
            if (bus.check_reset) cr_cnt++;

            if (m_trig_k >= 0 && k <= m_trig_k + CD && bus.mfi_valid
                && bus.mfi_order == m_order + 32'd1) m_ns = 1;
            if (m_trig_k >= 0 && k < m_trig_k + CD && bus.mfi_valid && bus.mfi_halt) m_hs = 1;
            if (e_elig) begin
                m_trig_k = k;
                m_order  = bus.mfi_order;
            end
            k++;
        end
    end

    task automatic clear_inputs();
        bus.mfi_valid = 1'b0;
        bus.mfi_order = '0;
        bus.mfi_halt  = 1'b0;
    endtask

    task automatic apply_inputs(input int kk);
        clear_inputs();
        foreach (evs[j]) begin
            if (evs[j].k == kk) begin
                bus.mfi_valid = 1'b1;
                bus.mfi_order = evs[j].order;
                bus.mfi_halt  = evs[j].halt;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            apply_inputs(i);
            @(posedge clock);
            #1;
        end
        clear_inputs();
    endtask

    task automatic add_ev(input int kk, input logic [31:0] order, input logic halt);
        ev_t e;
        e.k = kk; e.order = order; e.halt = halt;
        evs.push_back(e);
    endtask

    initial begin
        clear_inputs();

        // Trig at post-hold cycle 7 (k=9) with order 5; successor 3 cycles later.
        evs.delete(); add_ev(9, 32'd5, 0); add_ev(12, 32'd6, 0);
        do_reset(); run(40);
        chk("s1_trig_at", trig_at, 9);
        chk("s1_check_at", check_at, 25);
        chk("s1_n_trig", n_trig, 1);
        chk("s1_n_check", n_check, 1);
        chk("s1_trig_order", bus.trig_order, 32'd5);
        chk("s1_next_seen", bus.next_seen, 1);
        chk("s1_done", bus.done, 1);
        chk("s1_timeout", bus.timeout, 0);

        // No successor retirement.
        evs.delete(); add_ev(9, 32'd5, 0); add_ev(12, 32'd7, 0);
        do_reset(); run(40);
        chk("s2_next_seen", bus.next_seen, 0);
        chk("s2_done", bus.done, 1);

        // Early retirements, a halting one, then eligible at post-hold cycle 9.
        evs.delete();
        for (int i = 0; i < 4; i++) add_ev(2 + i, 32'(i + 1), 0);
        add_ev(7, 32'd9, 1); add_ev(11, 32'd20, 0); add_ev(15, 32'd30, 1);
        do_reset(); run(40);
        chk("s3_trig_at", trig_at, 11);
        chk("s3_check_at", check_at, 27);
        chk("s3_trig_order", bus.trig_order, 32'd20);
        chk("s3_halt_seen", bus.halt_seen, 1);
        chk("s3_next_seen", bus.next_seen, 0);

        // Timeout; a late retirement must not trig.
        evs.delete(); add_ev(70, 32'd3, 0);
        do_reset(); run(80);
        chk("s4_timeout", bus.timeout, 1);
        chk("s4_done", bus.done, 1);
        chk("s4_n_trig", n_trig, 0);
        chk("s4_n_check", n_check, 0);

        // Successor order wraps from all-ones to zero.
        evs.delete(); add_ev(6, 32'hFFFF_FFFF, 0); add_ev(8, 32'd0, 0);
        do_reset(); run(30);
        chk("s5_trig_at", trig_at, 6);
        chk("s5_trig_order", bus.trig_order, 32'hFFFF_FFFF);
        chk("s5_next_seen", bus.next_seen, 1);

        // Retirement exactly at the TRIG_MAX cycle still triggers.
        evs.delete(); add_ev(RC + TMAX, 32'd77, 0);
        do_reset(); run(90);
        chk("s6_trig_at", trig_at, RC + TMAX);
        chk("s6_check_at", check_at, RC + TMAX + CD);
        chk("s6_timeout", bus.timeout, 0);
        chk("s6_done", bus.done, 1);

        // Reset while ARMED aborts immediately; a fresh window follows.
        evs.delete(); add_ev(8, 32'd40, 0);
        do_reset(); run(14);
        reset = 1'b1;
        #1;
        chk("s7_abort_trig_order", bus.trig_order, 32'd0);
        chk("s7_abort_check_reset", bus.check_reset, 1);
        chk("s7_abort_state", 32'(bus.dbg_state), 32'(HOLD));
        evs.delete(); add_ev(7, 32'd50, 0);
        do_reset(); run(30);
        chk("s7_cr_cycles", cr_cnt, RC);
        chk("s7_trig_at", trig_at, 7);
        chk("s7_trig_order", bus.trig_order, 32'd50);
        chk("s7_check_at", check_at, 23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
